// File: rtl/masked_skinny4_sbox_pipe.sv
// Three-share masked SKINNY-64 4-bit S-box, one register stage per NOR-XOR round.
// Every stage register stores the nine uncompressed cross-share terms of its round,
// plus the shares of the untouched bits. Compression happens only on register outputs.

// One lane, one round. Takes the three round-input shares and produces the nine
// terms t[i][j] = x3'_i & x2'_j (with x0_i folded into t[i][i]) and the pass-through
// bits. The NOR is formed by complementing x3 and x2 on share 0 only.
// Packing: st[3*i+j] = t[i][j]; st[9+3*k +: 3] = {x3_k, x2_k, x1_k}.
module masked_skinny4_lane (
    input  logic [3:0]  s0,
    input  logic [3:0]  s1,
    input  logic [3:0]  s2,
    output logic [17:0] st
);
    logic [2:0][3:0] s;
    logic [2:0]      x3p;
    logic [2:0]      x2p;

    // Form the cross-share terms. Each t[i][j] depends on shares i and j only.
    always_comb begin
        s   = {s2, s1, s0};
        x3p = '0;
        x2p = '0;
        st  = '0;
        for (int i = 0; i < 3; i++) begin
            x3p[i] = s[i][3] ^ (i == 0);
            x2p[i] = s[i][2] ^ (i == 0);
        end
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                st[3*i+j] = (x3p[i] & x2p[j]) ^ ((i == j) ? s[i][0] : 1'b0);
            end
            st[9+3*i +: 3] = s[i][3:1];
        end
    end
endmodule

module masked_skinny4_sbox_pipe #(
    parameter int LANES  = 16,
    parameter int ROUNDS = 4    // SKINNY-64 needs exactly 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [4*LANES-1:0] in_sh0,
    input  logic [4*LANES-1:0] in_sh1,
    input  logic [4*LANES-1:0] in_sh2,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [4*LANES-1:0] out_sh0,
    output logic [4*LANES-1:0] out_sh1,
    output logic [4*LANES-1:0] out_sh2,
    output logic               busy
);
    localparam int SW = 18;

    logic [ROUNDS:1][LANES-1:0][SW-1:0] st_q, st_d, rnd_w;
    logic [ROUNDS:1]                    vld_pipe_q, vld_pipe_d;
    logic                               advance;

    // Fold the terms of share k back to one nibble. Share k reads only row k.
    // The bit rotation is applied after every round except the last one.
    function automatic logic [11:0] compress(input logic [SW-1:0] st, input logic rot);
        logic [3:0]  x;
        logic [11:0] res;
        res = '0;
        for (int k = 0; k < 3; k++) begin
            x = {st[9+3*k +: 3], st[3*k] ^ st[3*k+1] ^ st[3*k+2]};
            if (rot) x = {x[2:0], x[3]};
            res[4*k +: 4] = x;
        end
        return res;
    endfunction

    generate
        for (genvar r = 0; r < ROUNDS; r++) begin : g_rnd
            for (genvar l = 0; l < LANES; l++) begin : g_lane
                logic [11:0] rin;
                if (r == 0) begin : g_first
                    assign rin = {in_sh2[4*l +: 4], in_sh1[4*l +: 4], in_sh0[4*l +: 4]};
                end else begin : g_mid
                    assign rin = compress(st_q[r][l], 1'b1);
                end
                masked_skinny4_lane u_lane (
                    .s0 (rin[3:0]),
                    .s1 (rin[7:4]),
                    .s2 (rin[11:8]),
                    .st (rnd_w[r+1][l])
                );
            end
        end
        for (genvar l = 0; l < LANES; l++) begin : g_out
            logic [11:0] fin;
            assign fin = compress(st_q[ROUNDS][l], 1'b0);
            assign out_sh0[4*l +: 4] = fin[3:0];
            assign out_sh1[4*l +: 4] = fin[7:4];
            assign out_sh2[4*l +: 4] = fin[11:8];
        end
    endgenerate

    // Whole pipeline moves in lockstep. A stalled output freezes every stage.
    // Data loads regardless of valid; bubbles just carry a cleared valid bit.
    always_comb begin
        advance    = ~vld_pipe_q[ROUNDS] | out_ready;
        vld_pipe_d = vld_pipe_q;
        st_d       = st_q;
        if (advance) begin
            vld_pipe_d = {vld_pipe_q[ROUNDS-1:1], in_valid};
            st_d       = rnd_w;
        end
    end

    // Stage registers. Reset discards everything in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe_q <= '0;
            st_q       <= '0;
        end else begin
            vld_pipe_q <= vld_pipe_d;
            st_q       <= st_d;
        end
    end

    assign in_ready  = advance;
    assign out_valid = vld_pipe_q[ROUNDS];
    assign busy      = |vld_pipe_q;
endmodule

// File: tb/tb_masked_skinny4_sbox_pipe.sv
// Scoreboard bench for the masked SKINNY-64 S-box pipeline.
module tb_masked_skinny4_sbox_pipe;
    localparam int LANES = 16;
    localparam int W     = 4 * LANES;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b1;
    logic [W-1:0] in_sh0 = '0, in_sh1 = '0, in_sh2 = '0;
    logic         in_ready, out_valid, busy;
    logic [W-1:0] out_sh0, out_sh1, out_sh2;

    masked_skinny4_sbox_pipe #(.LANES(LANES), .ROUNDS(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sh0(in_sh0), .in_sh1(in_sh1), .in_sh2(in_sh2),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sh0(out_sh0), .out_sh1(out_sh1), .out_sh2(out_sh2),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] exp;
        int           cyc;
        bit           lat;
    } item_t;

    item_t        sb[$];
    int           n_cmp = 0;
    int           n_bad = 0;
    int           cyc = 0;
    bit           lat_en = 1'b0;
    logic [3:0]   sbox[16];
    logic [63:0]  tbl;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [3*W-1:0] act, input logic [3*W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: unmask, table lookup per nibble.
    function automatic logic [W-1:0] model(input logic [W-1:0] a, b, c);
        logic [W-1:0] x, r;
        x = a ^ b ^ c;
        r = '0;
        for (int l = 0; l < LANES; l++) r[4*l +: 4] = sbox[x[4*l +: 4]];
        return r;
    endfunction

    function automatic logic [W-1:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    // One cycle of stimulus; a vector accepted this cycle goes to the scoreboard.
    task automatic drive(input bit v, input logic [W-1:0] a, b, c);
        item_t it;
        @(posedge clk); #1;
        in_valid = v; in_sh0 = a; in_sh1 = b; in_sh2 = c;
        @(negedge clk);
        if (in_valid && in_ready) begin
            it.exp = model(a, b, c);
            it.cyc = cyc;
            it.lat = lat_en;
            sb.push_back(it);
        end
    endtask

    // Monitor: pop and compare on every transfer; check stability under stall.
    item_t          mit;
    logic [3*W-1:0] held;
    bit             hold_prev = 1'b0;
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (out_ready) begin
                if (sb.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_output: got out_valid=1 expected no output (t=%0t)", $time);
                end else begin
                    mit = sb.pop_front();
                    chk("sbox_out", out_sh0 ^ out_sh1 ^ out_sh2, mit.exp);
                    if (mit.lat) chk("latency", cyc - mit.cyc, 4);
                end
                hold_prev = 1'b0;
            end else begin
                if (hold_prev) chk("hold_stable", {out_sh2, out_sh1, out_sh0}, held);
                held      = {out_sh2, out_sh1, out_sh0};
                hold_prev = 1'b1;
            end
        end else begin
            hold_prev = 1'b0;
        end
    end

    initial begin
        logic [W-1:0] a, b, c;
        logic [3:0]   pat;
        tbl = 64'hc6901a2b385d4e7f;
        for (int i = 0; i < 16; i++) sbox[i] = tbl[63-4*i -: 4];

        // Reset state
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_sh", {out_sh2, out_sh1, out_sh0}, 0);
        @(negedge clk); rst_n = 1'b1;
        lat_en = 1'b1;

        // Unmasked exhaustive: lane l carries nibble l, then reversed
        for (int l = 0; l < LANES; l++) a[4*l +: 4] = 4'(l);
        drive(1, a, '0, '0);
        drive(1, ~a, '0, '0);
        // Same values under random masks
        b = rnd64(); c = rnd64();
        drive(1, a ^ b ^ c, b, c);

        // Random 3-share stream at full rate
        for (int n = 0; n < 10000; n++) begin
            drive(1, rnd64(), rnd64(), rnd64());
            chk("in_ready_full_rate", in_ready, 1);
        end
        repeat (6) drive(0, '0, '0, '0);

        // Backpressure: fill, stall 5 cycles, release
        lat_en = 1'b0;
        out_ready = 1'b0;
        repeat (4) drive(1, rnd64(), rnd64(), rnd64());
        for (int k = 0; k < 5; k++) begin
            drive(0, '0, '0, '0);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_busy", busy, 1);
            chk("bp_out_valid", out_valid, 1);
        end
        @(posedge clk); #1; out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("bp_drain_consecutive", out_valid, 1);
            if (k < 3) @(posedge clk);
        end
        @(posedge clk); @(negedge clk);
        chk("bp_drained", out_valid, 0);
        lat_en = 1'b1;

        // Bubbles: 1,0,1,0 in -> 1,0,1,0 out
        drive(1, rnd64(), rnd64(), rnd64());
        drive(0, '0, '0, '0);
        drive(1, rnd64(), rnd64(), rnd64());
        drive(0, '0, '0, '0);
        pat = '0;
        for (int k = 0; k < 4; k++) begin
            drive(0, '0, '0, '0);
            pat = {pat[2:0], out_valid};
        end
        chk("bubble_pattern", pat, 4'b1010);

        // Reset with 3 vectors in flight
        repeat (3) drive(1, rnd64(), rnd64(), rnd64());
        @(posedge clk); #2;
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_out_sh", {out_sh2, out_sh1, out_sh0}, 0);
        chk("midrst_in_ready", in_ready, 1);
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            drive(0, '0, '0, '0);
            chk("post_rst_no_stale", out_valid, 0);
        end

        // Recovery after reset, including the x=3 / x=f corners
        a = '0;
        for (int l = 0; l < LANES; l++) a[4*l +: 4] = (l % 2 == 0) ? 4'h3 : 4'hf;
        b = rnd64(); c = rnd64();
        drive(1, a ^ b ^ c, b, c);
        repeat (20) drive(1, rnd64(), rnd64(), rnd64());
        repeat (8) drive(0, '0, '0, '0);
        chk("scoreboard_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
